// File: rtl/vend_payout.sv
// Payout mechanism controller: turns one-cycle vend/change commands into timed
// motor and hopper pulses, tracking stock and hopper coin counts.
//
// state | meaning
// IDLE  | arbitrate pending work, start an actuation or drop an unservable command
// ACT   | exactly one actuator output held high
// GAP   | actuator released, spacing before the next arbitration
module vend_payout #(
    parameter int ACT_CYCLES = 4,
    parameter int GAP_CYCLES = 2,
    parameter int STOCK_INIT = 8,
    parameter int COIN_INIT  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic coin5,
    input  logic coin10,
    input  logic drop_water,
    input  logic drop_coke,
    input  logic drop_coffee,
    input  logic change5,
    input  logic change10,
    output logic motor_water,
    output logic motor_coke,
    output logic motor_coffee,
    output logic eject5,
    output logic eject10,
    output logic busy,
    output logic empty_water,
    output logic empty_coke,
    output logic empty_coffee,
    output logic overflow,
    output logic fault
);

    typedef enum logic [1:0] {IDLE, ACT, GAP} state_t;

    // The IDLE arbitration cycle counts as the last gap cycle, so starts are
    // exactly ACT_CYCLES + GAP_CYCLES apart.
    localparam logic [7:0] ACT_LOAD = 8'(ACT_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 2);

    state_t      state, state_nx;
    logic [7:0]  timer, timer_nx;
    logic [4:0]  req;
    logic [4:0]  svc;
    logic [2:0]  pend    [5];
    logic [2:0]  pend_nx [5];
    logic [7:0]  stock    [3];
    logic [7:0]  stock_nx [3];
    logic [2:0]  stock_dec;
    logic [7:0]  hop5, hop10, hop5_nx, hop10_nx;
    logic        hop5_dec, hop10_dec;
    logic        sec5, sec5_nx;
    logic [4:0]  act_q, act_nx;
    logic        found;
    logic        fault_set, ovf_set;
    logic        busy_nx;

    // command index: 0 water, 1 coke, 2 coffee, 3 change10, 4 change5
    // actuator index: 0 water, 1 coke, 2 coffee, 3 eject10, 4 eject5
    assign req = {change5, change10, drop_coffee, drop_coke, drop_water};

    assign motor_water  = act_q[0];
    assign motor_coke   = act_q[1];
    assign motor_coffee = act_q[2];
    assign eject10      = act_q[3];
    assign eject5       = act_q[4];

    function automatic logic [7:0] hop_next(input logic [7:0] h, input logic inc, input logic dec);
        if (inc && !dec && h != 8'hFF) return h + 8'd1;
        if (dec && !inc)               return h - 8'd1;
        return h;
    endfunction

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        act_nx    = act_q;
        svc       = '0;
        stock_dec = '0;
        hop5_dec  = 1'b0;
        hop10_dec = 1'b0;
        sec5_nx   = sec5;
        fault_set = 1'b0;
        found     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sec5) begin
                    act_nx[4] = 1'b1;
                    hop5_dec  = 1'b1;
                    sec5_nx   = 1'b0;
                end else begin
                    for (int i = 0; i < 5; i++) begin
                        if (!found && pend[i] != 3'd0) begin
                            found  = 1'b1;
                            svc[i] = 1'b1;
                        end
                    end
                    for (int i = 0; i < 3; i++) begin
                        if (svc[i]) begin
                            if (stock[i] != 8'd0) begin
                                act_nx[i]    = 1'b1;
                                stock_dec[i] = 1'b1;
                            end else begin
                                fault_set = 1'b1;
                            end
                        end
                    end
                    if (svc[3]) begin
                        if (hop10 != 8'd0) begin
                            act_nx[3] = 1'b1;
                            hop10_dec = 1'b1;
                        end else if (hop5 >= 8'd2) begin
                            act_nx[4] = 1'b1;
                            hop5_dec  = 1'b1;
                            sec5_nx   = 1'b1;
                        end else begin
                            fault_set = 1'b1;
                        end
                    end
                    if (svc[4]) begin
                        if (hop5 != 8'd0) begin
                            act_nx[4] = 1'b1;
                            hop5_dec  = 1'b1;
                        end else begin
                            fault_set = 1'b1;
                        end
                    end
                end
                if (act_nx != 5'd0) begin
                    state_nx = ACT;
                    timer_nx = ACT_LOAD;
                end
            end
            ACT: begin
                if (timer == 8'd0) begin
                    act_nx = '0;
                    if (GAP_CYCLES >= 2) begin
                        state_nx = GAP;
                        timer_nx = GAP_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer - 8'd1;
                end
            end
            GAP: begin
                if (timer == 8'd0) state_nx = IDLE;
                else               timer_nx = timer - 8'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ovf_set = 1'b0;
        busy_nx = (state_nx != IDLE) || sec5_nx;
        for (int i = 0; i < 5; i++) begin
            pend_nx[i] = pend[i];
            case ({req[i], svc[i]})
                2'b10: begin
                    if (pend[i] == 3'd7) ovf_set = 1'b1;
                    else                 pend_nx[i] = pend[i] + 3'd1;
                end
                2'b01:   pend_nx[i] = pend[i] - 3'd1;
                default: pend_nx[i] = pend[i];
            endcase
            if (pend_nx[i] != 3'd0) busy_nx = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            stock_nx[i] = stock_dec[i] ? stock[i] - 8'd1 : stock[i];
        end
        hop5_nx  = hop_next(hop5, coin5, hop5_dec);
        hop10_nx = hop_next(hop10, coin10, hop10_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            sec5         <= 1'b0;
            act_q        <= '0;
            hop5         <= 8'(COIN_INIT);
            hop10        <= 8'(COIN_INIT);
            busy         <= 1'b0;
            overflow     <= 1'b0;
            fault        <= 1'b0;
            empty_water  <= (STOCK_INIT == 0);
            empty_coke   <= (STOCK_INIT == 0);
            empty_coffee <= (STOCK_INIT == 0);
            for (int i = 0; i < 5; i++) pend[i]  <= '0;
            for (int i = 0; i < 3; i++) stock[i] <= 8'(STOCK_INIT);
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            sec5         <= sec5_nx;
            act_q        <= act_nx;
            hop5         <= hop5_nx;
            hop10        <= hop10_nx;
            busy         <= busy_nx;
            overflow     <= overflow | ovf_set;
            fault        <= fault | fault_set;
            empty_water  <= (stock_nx[0] == 8'd0);
            empty_coke   <= (stock_nx[1] == 8'd0);
            empty_coffee <= (stock_nx[2] == 8'd0);
            for (int i = 0; i < 5; i++) pend[i]  <= pend_nx[i];
            for (int i = 0; i < 3; i++) stock[i] <= stock_nx[i];
        end
    end

endmodule
